// File: rtl/fpu_mul_pkg.sv
// Shared definitions for the digit-serial mantissa multiplier: FSM state type
// and the radix-16 digit width.
package fpu_mul_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mant_row_gen.sv
// Combinational row generator: WIDTH-bit mantissa times one 4-bit digit,
// assembled from 4x4 partial-product cells into a WIDTH+4 bit row.
module mant_row_gen
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0]         i_a,
    input  logic [DIGIT_W-1:0]       i_digit,
    output logic [WIDTH+DIGIT_W-1:0] o_row
);

    localparam int NDIG = WIDTH / DIGIT_W;

    logic [2*DIGIT_W-1:0] pp [NDIG];

    for (genvar j = 0; j < NDIG; j++) begin : g_cell
        assign pp[j] = {{DIGIT_W{1'b0}}, i_a[j*DIGIT_W +: DIGIT_W]} *
                       {{DIGIT_W{1'b0}}, i_digit};
    end

    // Neighbouring 8-bit cells overlap by one nibble; the adder chain absorbs the carries.
    always_comb begin
        o_row = '0;
        for (int j = 0; j < NDIG; j++) begin
            o_row = o_row + ((WIDTH + DIGIT_W)'(pp[j]) << (DIGIT_W * j));
        end
    end

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential radix-16 mantissa multiplier: one B digit per CALC cycle, LSB first.
// Optional macro MANT_MUL_EARLY_TERM_EN stops once the remaining B digits are zero.
module mant_mul_seq
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int K_W  = $clog2(NDIG + 1);
    localparam int P_W  = 2 * WIDTH;

    mul_state_e state_q, state_d;
    logic [WIDTH-1:0]         a_q, a_d, b_q, b_d;
    logic [P_W-1:0]           acc_q, acc_d, prod_q, prod_d;
    logic [K_W-1:0]           k_q, k_d;
    logic                     ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;
    logic [DIGIT_W-1:0]       digit;
    logic [WIDTH+DIGIT_W-1:0] row;
    logic [P_W-1:0]           sum;
    logic                     last_digit, hi_zero;

    mant_row_gen #(.WIDTH(WIDTH)) u_row (
        .i_a    (a_q),
        .i_digit(digit),
        .o_row  (row)
    );

    always_comb begin
        digit      = DIGIT_W'(b_q >> (DIGIT_W * int'(k_q)));
        sum        = acc_q + (P_W'(row) << (DIGIT_W * int'(k_q)));
        last_digit = (k_q == K_W'(NDIG - 1));
`ifdef MANT_MUL_EARLY_TERM_EN
        hi_zero    = ((b_q >> (DIGIT_W * (int'(k_q) + 1))) == '0);
`else
        hi_zero    = 1'b0;
`endif

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        k_d     = k_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum;
                k_d   = k_q + K_W'(1);
                // The result register only moves on entry to DONE.
                if (last_digit || hi_zero) begin
                    prod_d  = sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
        busy_d  = (state_d == CALC);
    end

    always_ff @(posedge i_clk) begin
        a_q <= a_d;
        b_q <= b_d;
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            prod_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            prod_q  <= prod_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_product = prod_q;

endmodule
